// File: rtl/edge_framer.sv
// -----------------------------------------------------------------------------
// edge_framer
//
// Final stage of the Sobel magnitude pipeline, in the pixel-clock domain.
// Converts each magnitude into an output pixel and attaches start-of-frame,
// end-of-line and end-of-frame flags. Output goes through a two-entry skid
// buffer, so sink backpressure is honoured at one pixel per clock.
// The pixel transform is: shift right by SHIFT_P, then saturate to WIDTH_P bits.
//
// Optional feature (compile-time macro): EDGE_FRAMER_BINARY_EN
//   defined   : data_o is all ones when pixel >= thresh_i, otherwise zero
//   undefined : data_o is the saturated pixel, and thresh_i is ignored
//
// Ports:
//   clk_i     in   1          pixel clock; all logic on the rising edge
//   rstn_i    in   1          asynchronous active-low reset
//   valid_i   in   1          magnitude valid
//   ready_o   out  1          block can accept a magnitude (registered)
//   mag_i     in   2*WIDTH_P  unsigned magnitude
//   thresh_i  in   WIDTH_P    binarisation threshold, sampled at accept
//   valid_o   out  1          output pixel valid
//   ready_i   in   1          sink ready
//   data_o    out  WIDTH_P    output pixel
//   sof_o     out  1          pixel is at x=0, y=0
//   eol_o     out  1          pixel is at x=LINE_W_P-1
//   eof_o     out  1          pixel is at x=LINE_W_P-1, y=FRAME_H_P-1
// -----------------------------------------------------------------------------
module edge_framer #(
    parameter int WIDTH_P   = 8,
    parameter int LINE_W_P  = 640,
    parameter int FRAME_H_P = 480,
    parameter int SHIFT_P   = 0
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [2*WIDTH_P-1:0]   mag_i,
    input  logic [WIDTH_P-1:0]     thresh_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [WIDTH_P-1:0]     data_o,
    output logic                   sof_o,
    output logic                   eol_o,
    output logic                   eof_o
);

    localparam int XW = (LINE_W_P  > 1) ? $clog2(LINE_W_P)  : 1;
    localparam int YW = (FRAME_H_P > 1) ? $clog2(FRAME_H_P) : 1;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    // One buffered pixel: data plus the position flags that travel with it.
    typedef struct packed {
        logic [WIDTH_P-1:0] data;
        logic               sof;
        logic               eol;
        logic               eof;
    } pix_t;

    state_t              state, state_nx;
    pix_t                out_q, skid_q, in_pix;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic                accept, transfer;
    logic                x_last, y_last;
    logic                load_out, load_skid, skid_to_out;
    logic [2*WIDTH_P-1:0] shifted;
    logic [WIDTH_P-1:0]  sat;

    assign accept   = valid_i & ready_o;
    assign transfer = valid_o & ready_i;

    // ---------------- pixel transform ----------------
    assign shifted = mag_i >> SHIFT_P;
    // Any set bit above the output width means the value exceeds full scale.
    assign sat     = (|shifted[2*WIDTH_P-1:WIDTH_P]) ? '1 : shifted[WIDTH_P-1:0];

`ifdef EDGE_FRAMER_BINARY_EN
    assign in_pix.data = (sat >= thresh_i) ? '1 : '0;
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh_i;
    assign in_pix.data   = sat;
`endif

    // Flags come from the position before this pixel's increment.
    assign x_last     = (x == XW'(LINE_W_P - 1));
    assign y_last     = (y == YW'(FRAME_H_P - 1));
    assign in_pix.sof = (x == '0) && (y == '0);
    assign in_pix.eol = x_last;
    assign in_pix.eof = x_last && y_last;

    // ---------------- position counters ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // ---------------- skid buffer control ----------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nx    = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (accept && transfer) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_nx  = TWO;
                    load_skid = 1'b1;
                end else if (transfer) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                // ready_o is low here, so no accept can coincide.
                if (transfer) begin
                    state_nx    = ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= EMPTY;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_nx;
            // Both handshake outputs are registered from the next state, so
            // ready_o is already low in the first cycle spent in TWO.
            valid_o <= (state_nx != EMPTY);
            ready_o <= (state_nx != TWO);
            if (load_out) begin
                out_q <= in_pix;
            end else if (skid_to_out) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_pix;
            end
        end
    end

    assign data_o = out_q.data;
    assign sof_o  = out_q.sof;
    assign eol_o  = out_q.eol;
    assign eof_o  = out_q.eof;

endmodule
